ball_motion_engine: RTL and testbench
=====================================

// Module: ball_motion_engine
// PURPOSE
//   Per-frame position engine for the bouncing-ball demo. Sits directly upstream of the
//   ball pixel renderer inside tt_um_rebeccargb_tt09ball_gdsart and is fed by the VGA sync
//   generator's frame tick. On each tick it advances the ball by a programmable step and
//   reflects the ball off the screen edges. It presents a stable, double-buffered (x, y)
//   to the renderer, plus per-edge bounce pulses for colour and sound effects.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   V_ACTIVE  480  visible lines per frame
//   BALL_W    32   ball width in pixels
//   BALL_H    32   ball height in pixels
//   X_INIT    100  reset x position (left edge of ball)
//   Y_INIT    60   reset y position (top edge of ball)
// PORTS
//   clk          in   1   pixel clock, single clock domain
//   rst_n        in   1   reset, asynchronous assert, active low
//   ena          in   1   design enable; frame ticks are ignored while low
//   frame_tick   in   1   one-cycle pulse from sync generator at start of vblank
//   pause        in   1   when high at a tick, that frame's update is skipped
//   speed        in   2   step size = speed+1 pixels per frame on each axis (1..4)
//   ball_x       out  10  committed left-edge x, 0..H_ACTIVE-BALL_W
//   ball_y       out  10  committed top-edge y, 0..V_ACTIVE-BALL_H
//   busy         out  1   update in progress
//   bounce_x     out  1   one-cycle pulse: x direction flipped at this commit
//   bounce_y     out  1   one-cycle pulse: y direction flipped at this commit
// BEHAVIOUR
//   Reset: ball_x=X_INIT, ball_y=Y_INIT, dx=+1, dy=+1, state IDLE.
//     busy=0, bounce_x=0, bounce_y=0.
//   FSM: IDLE -> STEP_X -> STEP_Y -> COMMIT -> IDLE.
//     IDLE->STEP_X only when frame_tick & ena & ~pause are sampled high at edge E0.
//     speed is latched at E0.
//     Working regs nx/ny compute in STEP_X (edge E1) and STEP_Y (edge E2).
//     COMMIT copies nx/ny to ball_x/ball_y at edge E3.
//     bounce_* are high for exactly the cycle after E3.
//   busy: high from E0 until E3 (3 cycles); low in IDLE.
//   A frame_tick arriving while busy is dropped: no queueing, no state change.
//   Limits: XMAX=H_ACTIVE-BALL_W, YMAX=V_ACTIVE-BALL_H. Arithmetic is 11-bit to avoid wrap.
//   X axis with dx=+1:
//     if x+step >= XMAX then nx=XMAX, dx<=-1, flag bounce_x;
//     else nx=x+step.
//   X axis with dx=-1:
//     if x <= step then nx=0, dx<=+1, flag bounce_x;
//     else nx=x-step.
//   Y axis: identical rules using YMAX, dy and bounce_y.
//   Touching a limit exactly counts as a bounce.
//   Corner hit: bounce_x and bounce_y pulse in the same cycle.
//   Direction flags update at COMMIT, together with the position.
//   ball_x/ball_y never change outside the E3 edge, so the renderer never sees a torn pair.
//   Pause or ena low: position, direction and outputs hold; the FSM stays in IDLE.
//   Reset asserted mid-update: async return to reset values; the partial update is discarded.
// TESTING
//   T1 reset: assert rst_n=0 -> ball_x=100, ball_y=60, busy=0, bounce_x=0, bounce_y=0.
//   T2 step: speed=0, one tick -> busy high 3 cycles; ball_x=101, ball_y=61 after E3.
//      No bounce pulses.
//   T3 right wall: preload to x=607 via ticks, speed=3, tick -> x=608, bounce_x one cycle.
//      Next tick -> x=604.
//   T4 corner: reach x=607, y=447 with speed=0, tick -> x=608, y=448.
//      bounce_x and bounce_y coincide; next tick -> 607, 447.
//   T5 gating: pause=1 tick and ena=0 tick -> no change.
//      Second tick 1 cycle after first -> ignored; exactly one step applied.
//   T6 reset mid-op: drop rst_n during STEP_Y -> outputs immediately return to 100/60, busy=0.

Source files
------------

// File: rtl/ball_motion_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ball_motion_engine                                                       |
// | Per-frame ball position stepper with edge reflection and bounce pulses.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ball_motion_engine #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BALL_W   = 32,
    parameter int BALL_H   = 32,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       busy,
    output logic       bounce_x,
    output logic       bounce_y
);

    localparam logic [10:0] c_XMAX = 11'(H_ACTIVE - BALL_W);
    localparam logic [10:0] c_YMAX = 11'(V_ACTIVE - BALL_H);
    localparam logic [9:0]  c_XLIM = c_XMAX[9:0];
    localparam logic [9:0]  c_YLIM = c_YMAX[9:0];

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STEP_X = 2'd1;
    localparam logic [1:0] c_ST_STEP_Y = 2'd2;
    localparam logic [1:0] c_ST_COMMIT = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_step;
    logic [9:0]  r_nx;
    logic [9:0]  r_ny;
    logic        r_dx_neg;
    logic        r_dy_neg;
    logic        r_ndx_neg;
    logic        r_ndy_neg;
    logic        r_flag_x;
    logic        r_flag_y;

    logic [10:0] w_step_wide;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic        w_hit_x;
    logic        w_hit_y;
    logic [9:0]  w_nx;
    logic [9:0]  w_ny;

    // Sums are one bit wider than the position so the limit compare never wraps.
    always_comb begin
        w_step_wide = {8'd0, r_step};
        w_x_sum     = {1'b0, ball_x} + w_step_wide;
        w_y_sum     = {1'b0, ball_y} + w_step_wide;
        w_hit_x     = r_dx_neg ? ({1'b0, ball_x} <= w_step_wide) : (w_x_sum >= c_XMAX);
        w_hit_y     = r_dy_neg ? ({1'b0, ball_y} <= w_step_wide) : (w_y_sum >= c_YMAX);
        w_nx        = r_dx_neg ? (ball_x - {7'd0, r_step}) : w_x_sum[9:0];
        w_ny        = r_dy_neg ? (ball_y - {7'd0, r_step}) : w_y_sum[9:0];
        if (w_hit_x) begin
            w_nx = r_dx_neg ? 10'd0 : c_XLIM;
        end
        if (w_hit_y) begin
            w_ny = r_dy_neg ? 10'd0 : c_YLIM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_step    <= 3'd1;
            r_nx      <= 10'(X_INIT);
            r_ny      <= 10'(Y_INIT);
            r_dx_neg  <= 1'b0;
            r_dy_neg  <= 1'b0;
            r_ndx_neg <= 1'b0;
            r_ndy_neg <= 1'b0;
            r_flag_x  <= 1'b0;
            r_flag_y  <= 1'b0;
            ball_x    <= 10'(X_INIT);
            ball_y    <= 10'(Y_INIT);
            busy      <= 1'b0;
            bounce_x  <= 1'b0;
            bounce_y  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    bounce_x <= 1'b0;
                    bounce_y <= 1'b0;
                    if (frame_tick && ena && !pause) begin
                        r_step  <= {1'b0, speed} + 3'd1;
                        busy    <= 1'b1;
                        r_state <= c_ST_STEP_X;
                    end
                end
                c_ST_STEP_X: begin
                    r_nx      <= w_nx;
                    r_flag_x  <= w_hit_x;
                    r_ndx_neg <= r_dx_neg ^ w_hit_x;
                    r_state   <= c_ST_STEP_Y;
                end
                c_ST_STEP_Y: begin
                    r_ny      <= w_ny;
                    r_flag_y  <= w_hit_y;
                    r_ndy_neg <= r_dy_neg ^ w_hit_y;
                    r_state   <= c_ST_COMMIT;
                end
                c_ST_COMMIT: begin
                    // Position and direction change together so the pair is never torn.
                    ball_x   <= r_nx;
                    ball_y   <= r_ny;
                    r_dx_neg <= r_ndx_neg;
                    r_dy_neg <= r_ndy_neg;
                    bounce_x <= r_flag_x;
                    bounce_y <= r_flag_y;
                    busy     <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ball_motion_engine                                                    |
// | Randomized bench for ball_motion_engine against a frame-level model.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_ball_motion_engine;

    localparam int c_XMAX = 608;
    localparam int c_YMAX = 448;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       frame_tick;
    logic       pause;
    logic [1:0] speed;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       busy;
    logic       bounce_x;
    logic       bounce_y;

    int n_checks;
    int n_errors;
    int mx, my, mdx, mdy;
    int last_bx, last_by;

    ball_motion_engine u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .frame_tick (frame_tick),
        .pause      (pause),
        .speed      (speed),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .busy       (busy),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 100; my = 60; mdx = 1; mdy = 1;
    endtask

    // One axis of the frame update: move by s, reflect at 0 or lim.
    task automatic model_axis(inout int p, inout int d, input int s, input int lim, output int b);
        b = 0;
        if (d > 0) begin
            if (p + s >= lim) begin p = lim; d = -1; b = 1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 1; b = 1; end
            else p = p - s;
        end
    endtask

    task automatic do_frame(input int sp, input bit pz, input bit en, input bit extra);
        int ox, oy, ebx, eby;
        bit acc;
        ox = mx; oy = my;
        acc = en && !pz;
        @(negedge clk);
        speed = 2'(sp); pause = pz; ena = en; frame_tick = 1'b1;
        @(posedge clk); #1;
        check("busy_e0", busy, int'(acc));
        @(negedge clk);
        frame_tick = acc ? extra : 1'b0;
        speed = 2'($urandom_range(0, 3));
        if (acc) begin
            model_axis(mx, mdx, sp + 1, c_XMAX, ebx);
            model_axis(my, mdy, sp + 1, c_YMAX, eby);
            @(posedge clk); #1;
            check("busy_e1", busy, 1);
            check("hold_x", ball_x, ox);
            @(negedge clk);
            frame_tick = 1'b0;
            @(posedge clk); #1;
            check("busy_e2", busy, 1);
            check("hold_y", ball_y, oy);
            @(posedge clk); #1;
            check("busy_e3", busy, 0);
            check("pos_x", ball_x, mx);
            check("pos_y", ball_y, my);
            check("bounce_x", bounce_x, ebx);
            check("bounce_y", bounce_y, eby);
            last_bx = int'(bounce_x); last_by = int'(bounce_y);
            @(posedge clk); #1;
            check("bounce_x_clr", bounce_x, 0);
            check("bounce_y_clr", bounce_y, 0);
            check("idle_busy", busy, 0);
        end else begin
            last_bx = 0; last_by = 0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("gate_busy", busy, 0);
            check("gate_x", ball_x, ox);
            check("gate_y", ball_y, oy);
        end
        pause = 1'b0; ena = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int s, distx, disty, lx, loss, ox, oy;
        bit reached;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; ena = 1'b1; frame_tick = 1'b0; pause = 1'b0; speed = 2'd0;
        model_reset();

        // T1 reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", ball_x, 100);
        check("rst_y", ball_y, 60);
        check("rst_busy", busy, 0);
        check("rst_bx", bounce_x, 0);
        check("rst_by", bounce_y, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2 single step
        do_frame(0, 0, 1, 0);
        check("t2_x", ball_x, 101);
        check("t2_y", ball_y, 61);
        check("t2_nobounce", last_bx + last_by, 0);

        // T3 right wall
        while (mx < 607) begin
            s = (607 - mx < 4) ? 607 - mx : 4;
            do_frame(s - 1, 0, 1, 0);
        end
        check("t3_pre", ball_x, 607);
        do_frame(3, 0, 1, 0);
        check("t3_wall", ball_x, 608);
        check("t3_bx", last_bx, 1);
        do_frame(3, 0, 1, 0);
        check("t3_back", ball_x, 604);

        // T5 gating and dropped tick
        do_frame(1, 1, 1, 0);
        do_frame(1, 0, 0, 0);
        check("t5_hold", ball_x, 604);
        ox = mx;
        do_frame(1, 0, 1, 1);
        check("t5_once", ball_x, ox - 2);

        // randomized frames
        for (int i = 0; i < 150; i++) begin
            bit pz, en;
            pz = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 7) != 0);
            do_frame(int'($urandom_range(0, 3)), pz, en, 1'($urandom_range(0, 1)));
        end

        // T6 reset during STEP_Y
        if (mx == 100 && my == 60) do_frame(0, 0, 1, 0);
        @(negedge clk);
        speed = 2'd2; pause = 1'b0; ena = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_x", ball_x, 100);
        check("t6_y", ball_y, 60);
        check("t6_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_frame(0, 0, 1, 0);
        check("t6_after_x", ball_x, 101);
        check("t6_after_y", ball_y, 61);

        // T4 corner: plan steps from reset; 8 pixels of clamp loss on x aligns the axes.
        pulse_reset();
        lx = 8;
        reached = 1'b0;
        for (int f = 0; f < 8000 && !reached; f++) begin
            distx = (mdx > 0) ? c_XMAX - mx : mx;
            disty = (mdy > 0) ? c_YMAX - my : my;
            s = 4;
            if (lx > 0 && distx < 4) begin
                s = (distx + lx < 4) ? distx + lx : 4;
            end else begin
                if (s > distx) s = distx;
                if (mdx > 0 && distx >= 2 && s > distx - 1) s = distx - 1;
            end
            if (s > disty) s = disty;
            if (mdy > 0 && disty >= 2 && s > disty - 1) s = disty - 1;
            loss = (s > distx) ? s - distx : 0;
            lx = lx - loss;
            do_frame(s - 1, 0, 1, 0);
            reached = (mx == 607 && mdx > 0 && my == 447 && mdy > 0);
        end
        check("t4_reach", int'(reached), 1);
        check("t4_pre_x", ball_x, 607);
        check("t4_pre_y", ball_y, 447);
        do_frame(0, 0, 1, 0);
        check("t4_x", ball_x, 608);
        check("t4_y", ball_y, 448);
        check("t4_both", last_bx + last_by, 2);
        do_frame(0, 0, 1, 0);
        check("t4_back_x", ball_x, 607);
        check("t4_back_y", ball_y, 447);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
